// File: rtl/nn_pkg.sv
// Shared types and constants for the dense-layer datapath (feeder, neuron, node).
// Latency: none; types, constants and a width helper only.
// Backpressure: none.
package nn_pkg;

   // Width of every data word moving between memories, feeder and neuron.
   localparam int DATA_W = 32;

   // Feeder sequencing states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOADB  = 3'd1,
      STREAM = 3'd2,
      WAIT   = 3'd3,
      OUTPUT = 3'd4
   } feeder_state_t;

   // Bits needed for a counter running 0 .. max_count-1 (at least one bit).
   function automatic int cnt_width(input int max_count);
      return (max_count <= 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Address generator for the neuron feeder: input index i, output index n, weight row pointer.
// Latency: addresses are registers; they update on the edge where clear/step/next is seen.
// Backpressure: none internally; the feeder FSM simply stops issuing step/next.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   clear               accepted layer start: n=0, i=0, row base=0
//   step                advance i (and the weight address) by one within the row
//   next                move to output neuron n+1: i=0, row base += VEC_LEN
//   x_addr              current i, doubles as the x memory address
//   w_addr              n*VEC_LEN + i, kept as a running pointer
//   n_idx               current output neuron index, doubles as the bias address
//   last_beat           i == VEC_LEN-1
//   last_neuron         n == NUM_OUT-1
module feeder_addr_gen
   import nn_pkg::*;
#(
   parameter int VEC_LEN = 784,
   parameter int NUM_OUT = 10,
   parameter int X_AW    = 10,
   parameter int W_AW    = 13,
   parameter int OUT_W   = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             step,
   input  logic             next,
   output logic [X_AW-1:0]  x_addr,
   output logic [W_AW-1:0]  w_addr,
   output logic [OUT_W-1:0] n_idx,
   output logic             last_beat,
   output logic             last_neuron
);

   localparam logic [X_AW-1:0]  I_LAST     = X_AW'(VEC_LEN - 1);
   localparam logic [OUT_W-1:0] N_LAST     = OUT_W'(NUM_OUT - 1);
   localparam logic [W_AW-1:0]  ROW_STRIDE = W_AW'(VEC_LEN);

   // Start address of the current weight row, n*VEC_LEN, built by repeated
   // addition so no multiplier is needed.
   logic [W_AW-1:0] row_base;
   logic [W_AW-1:0] next_base;

   assign next_base = row_base + ROW_STRIDE;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_addr   <= '0;
         w_addr   <= '0;
         n_idx    <= '0;
         row_base <= '0;
      end else if (clear) begin
         x_addr   <= '0;
         w_addr   <= '0;
         n_idx    <= '0;
         row_base <= '0;
      end else if (next) begin
         x_addr   <= '0;
         w_addr   <= next_base;
         row_base <= next_base;
         n_idx    <= n_idx + 1'b1;
      end else if (step) begin
         x_addr   <= x_addr + 1'b1;
         w_addr   <= w_addr + 1'b1;
      end
   end

   assign last_beat   = (x_addr == I_LAST);
   assign last_neuron = (n_idx == N_LAST);

endmodule

// File: rtl/neuron_feeder.sv
// Sequencer that streams one dense layer through a single time-multiplexed neuron.
// Latency: 2 + VEC_LEN + neuron latency + handshake cycles per output neuron.
// Backpressure: res_ready low stalls only in OUTPUT; result is held, no buffering, no reads issued.
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   start / busy / error   layer start pulse, run-in-progress flag, sticky timeout flag
//   x_addr / x_rdata       input vector memory, 1-cycle read latency
//   w_addr / w_rdata       weight memory (n*VEC_LEN + i), 1-cycle read latency
//   b_addr / b_rdata       bias memory (n), 1-cycle read latency
//   w/x/b/head_neuron      operands and first-beat marker to the neuron
//   relu_out / relu_done   neuron result and its completion strobe
//   res_data/res_idx       (index, value) result, res_valid/res_ready handshake
module neuron_feeder
   import nn_pkg::*;
#(
   parameter int VEC_LEN = 784,
   parameter int NUM_OUT = 10,
   parameter int X_AW    = 10,
   parameter int W_AW    = 13,
   parameter int OUT_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              error,
   output logic [X_AW-1:0]   x_addr,
   input  logic [DATA_W-1:0] x_rdata,
   output logic [W_AW-1:0]   w_addr,
   input  logic [DATA_W-1:0] w_rdata,
   output logic [OUT_W-1:0]  b_addr,
   input  logic [DATA_W-1:0] b_rdata,
   output logic [DATA_W-1:0] w_neuron,
   output logic [DATA_W-1:0] x_neuron,
   output logic [DATA_W-1:0] b_neuron,
   output logic              head_neuron,
   input  logic [DATA_W-1:0] relu_out,
   input  logic              relu_done,
   output logic [DATA_W-1:0] res_data,
   output logic [OUT_W-1:0]  res_idx,
   output logic              res_valid,
   input  logic              res_ready
);

   localparam int               TMO_W    = cnt_width(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   feeder_state_t    state;
   logic [TMO_W-1:0] tmo_cnt;
   logic             beat_vld;
   logic             b_load;
   logic [OUT_W-1:0] n_idx;
   logic             last_beat;
   logic             last_neuron;
   logic             ag_clear;
   logic             ag_step;
   logic             ag_next;
   logic             accept;

   // res_valid is high exactly while in OUTPUT, so acceptance needs only the state.
   assign accept   = (state == OUTPUT) && res_ready;
   assign ag_clear = (state == IDLE) && start;
   assign ag_step  = (state == STREAM) && !last_beat;
   assign ag_next  = accept && !last_neuron;

   feeder_addr_gen #(
      .VEC_LEN (VEC_LEN),
      .NUM_OUT (NUM_OUT),
      .X_AW    (X_AW),
      .W_AW    (W_AW),
      .OUT_W   (OUT_W)
   ) u_addr_gen (
      .clock       (clock),
      .reset_n     (reset_n),
      .clear       (ag_clear),
      .step        (ag_step),
      .next        (ag_next),
      .x_addr      (x_addr),
      .w_addr      (w_addr),
      .n_idx       (n_idx),
      .last_beat   (last_beat),
      .last_neuron (last_neuron)
   );

   // The bias memory is addressed by n throughout; its read in LOADB is the
   // one that gets captured into b_neuron.
   assign b_addr = n_idx;

   // Memory read data arrives one cycle after its address. beat_vld marks the
   // cycles carrying a real beat; outside them the operands are forced to zero
   // so any extra accumulation in the neuron adds nothing.
   assign x_neuron = beat_vld ? x_rdata : '0;
   assign w_neuron = beat_vld ? w_rdata : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         error       <= 1'b0;
         beat_vld    <= 1'b0;
         head_neuron <= 1'b0;
         b_load      <= 1'b0;
         b_neuron    <= '0;
         tmo_cnt     <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_idx     <= '0;
      end else begin
         // Alignment stage: flags for the address issued this cycle line up
         // with its read data next cycle.
         beat_vld    <= (state == STREAM);
         head_neuron <= (state == STREAM) && (x_addr == '0);

         // Bias read issued in LOADB returns during the first STREAM cycle and
         // is latched so it is stable from the head beat until the next LOADB.
         b_load <= (state == LOADB);
         if (b_load) begin
            b_neuron <= b_rdata;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  error <= 1'b0;
                  state <= LOADB;
               end
            end

            LOADB: begin
               state <= STREAM;
            end

            STREAM: begin
               if (last_beat) begin
                  tmo_cnt <= '0;
                  state   <= WAIT;
               end
            end

            WAIT: begin
               if (relu_done) begin
                  res_data  <= relu_out;
                  res_idx   <= n_idx;
                  res_valid <= 1'b1;
                  state     <= OUTPUT;
               end else if (tmo_cnt == TMO_LAST) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            OUTPUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (last_neuron) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= LOADB;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
